// File: rtl/fib_bcd_conv_if.sv
// Handshake bundle between a term source, the BCD converter and its consumer.
//   in_valid / in_ready / bin    : binary term offered to the converter
//   out_valid / out_ready / bcd  : packed BCD result offered downstream
// master: the side that supplies terms and consumes results.
// slave : the converter.
interface fib_bcd_conv_if #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;

    modport master (
        output in_valid, bin, out_ready,
        input  in_ready, out_valid, bcd
    );

    modport slave (
        input  in_valid, bin, out_ready,
        output in_ready, out_valid, bcd
    );
endinterface

// File: rtl/fib_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// cycle. A term is accepted in IDLE, converted over WIDTH cycles in CONV,
// and held in DONE until the consumer takes it.
//   clk : system clock, rising edge
//   clr : synchronous active-low reset
//   bus : fib_bcd_conv_if.slave (in_valid/in_ready/bin, out_valid/out_ready/bcd)
// bcd keeps the last completed result until the next completion or reset.
module fib_bcd_conv #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 5
) (
    input  logic              clk,
    input  logic              clr,
    fib_bcd_conv_if.slave     bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t                state;
    logic [WIDTH-1:0]      bin_sr;
    logic [4*DIGITS-1:0]   work;
    logic [4*DIGITS-1:0]   adj;
    logic [4*DIGITS-1:0]   nxt_work;
    logic [CW-1:0]         cnt;
    logic [4*DIGITS-1:0]   bcd_r;
    logic                  out_valid_r;

    // Per-nibble correction, no carry between digits, then shift in the
    // next binary MSB.
    always_comb begin
        adj = work;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
        end
        nxt_work = {adj[4*DIGITS-2:0], bin_sr[WIDTH-1]};
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state       <= IDLE;
            bin_sr      <= '0;
            work        <= '0;
            cnt         <= '0;
            bcd_r       <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        bin_sr <= bus.bin;
                        work   <= '0;
                        cnt    <= '0;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    work   <= nxt_work;
                    bin_sr <= {bin_sr[WIDTH-2:0], 1'b0};
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bcd_r       <= nxt_work;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.bcd       = bcd_r;
endmodule

// File: tb/tb_fib_bcd_conv.sv
module tb_fib_bcd_conv;
    localparam int WIDTH  = 14;
    localparam int DIGITS = 5;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    fib_bcd_conv_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    fib_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;
    int          rdy_mode = 0;   // 0: ready high, 1: random, 2: ready low
    bit          mon_on = 1'b0;

    logic [4*DIGITS-1:0] exp_q[$];
    int unsigned         acc_q[$];
    logic [4*DIGITS-1:0] last_exp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: decimal digits via division, independent of the add-3 method.
    function automatic logic [4*DIGITS-1:0] to_bcd(int unsigned v);
        logic [4*DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // out_ready driver: single process owns the signal.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard.
    bit prev_v = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_on && clr) begin
                if (bus.out_valid && !prev_v) begin
                    if (acc_q.size() == 0)
                        chk("unexpected_output", 1, 0);
                    else
                        chk("latency", longint'(cyc - acc_q.pop_front()), WIDTH);
                end
                if (bus.out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("result_without_term", 1, 0);
                    end else begin
                        chk("bcd", bus.bcd, exp_q[0]);
                        chk("in_ready_in_done", bus.in_ready, 0);
                        if (bus.out_ready) last_exp = exp_q.pop_front();
                    end
                end else begin
                    chk("bcd_hold", bus.bcd, last_exp);
                end
                prev_v = bus.out_valid;
            end else begin
                prev_v = 1'b0;
            end
        end
    end

    // Offer one term; returns the cycle stamp of the accepting edge.
    task automatic send(input int unsigned v, output int unsigned acc);
        int unsigned t;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", 0, 1);
            acc = 0;
            return;
        end
        bus.in_valid = 1'b1;
        bus.bin      = WIDTH'(v);
        @(posedge clk);
        #1;
        acc = cyc;
        exp_q.push_back(to_bcd(v));
        acc_q.push_back(acc);
        bus.in_valid = 1'b0;
        bus.bin      = WIDTH'($urandom);
    endtask

    task automatic wait_drain();
        int unsigned t;
        t = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    int unsigned fib_list[] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 6765, 10946};

    initial begin
        int unsigned acc, prev_acc, t;
        bus.in_valid = 1'b0;
        bus.bin      = '0;

        // Reset with random inputs for two edges.
        rdy_mode = 1;
        clr = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'($urandom);
            bus.bin      = WIDTH'($urandom);
        end
        @(negedge clk);
        chk("reset_bcd", bus.bcd, 0);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b0;
        clr = 1'b1;
        last_exp = '0;
        mon_on = 1'b1;

        // Single conversion, then back-to-back interval.
        rdy_mode = 0;
        send(13, acc);
        prev_acc = acc;

        // Fibonacci sweep, ready held high: WIDTH+2 between acceptances.
        foreach (fib_list[i]) begin
            send(fib_list[i], acc);
            chk("accept_interval", longint'(acc - prev_acc), WIDTH + 2);
            prev_acc = acc;
        end
        wait_drain();

        // Boundaries.
        send(16383, acc);
        send(0, acc);
        wait_drain();

        // Backpressure with an ignored term offered during DONE.
        rdy_mode = 2;
        send(377, acc);
        t = 0;
        while (!bus.out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("bp_reached_done", bus.out_valid, 1);
        bus.in_valid = 1'b1;
        bus.bin      = WIDTH'(99);
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_bcd", bus.bcd, 20'h00377);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        rdy_mode = 0;
        wait_drain();

        // Randomized traffic with random backpressure and gaps.
        rdy_mode = 1;
        repeat (30) begin
            send($urandom_range(0, (1 << WIDTH) - 1), acc);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        rdy_mode = 0;
        wait_drain();

        // Reset during the 7th CONV cycle of 6765.
        send(6765, acc);
        repeat (6) @(posedge clk);
        #1;
        clr = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        acc_q.delete();
        last_exp = '0;
        @(negedge clk);
        chk("midrst_bcd", bus.bcd, 0);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        clr = 1'b1;
        send(21, acc);
        wait_drain();

        repeat (20) @(negedge clk);
        chk("final_queue_empty", acc_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
